// File: rtl/alu_pkg.sv
// alu_pkg: shared op encodings, FSM states and flag bundle for the sequential ALU
package alu_pkg;
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_MUL = 3'b111
  } alop_t;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;
  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;
endpackage

// File: rtl/seq_nbit_alu_if.sv
// seq_nbit_alu_if: operand/result valid-ready bus between producer and the ALU
interface seq_nbit_alu_if
  import alu_pkg::*;
#(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  alop_t        alop;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_z;
  logic         flag_n;
  logic         flag_c;
  logic         flag_v;
  modport master (
    output in_valid, a, b, c_in, alop, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v
  );
  modport slave (
    input  in_valid, a, b, c_in, alop, out_ready,
    output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v
  );
endinterface

// File: rtl/shift_add_mul.sv
// shift_add_mul: iterative W-cycle shift-add unsigned multiplier
module shift_add_mul #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);
  localparam int SHW = $clog2(W);
  logic [W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic [2*W-1:0] addend;
  assign addend  = mplier_q[0] ? ({{W{1'b0}}, mcand_q} << cnt_q) : '0;
  assign product = acc_q + addend;
  assign done    = busy_q && (cnt_q == SHW'(W - 1));
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = product;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      busy_d   = !done;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end
endmodule

// File: rtl/seq_nbit_alu.sv
// seq_nbit_alu: registered valid/ready ALU with flags, barrel shift and iterative multiply
module seq_nbit_alu
  import alu_pkg::*;
#(
  parameter int W   = 32,
  parameter int SHW = $clog2(W)
) (
  input  logic clk,
  input  logic rst_n,
  seq_nbit_alu_if.slave bus
);
  state_t         state_q, state_d;
  logic [W-1:0]   result_q, result_d;
  flags_t         flags_q, flags_d;
  logic           is_sub, is_arith;
  logic [W-1:0]   bb, alu_r;
  logic [W:0]     sum;
  logic           alu_c, alu_v;
  logic           mul_start, mul_done;
  logic [2*W-1:0] product;
  assign mul_start = (state_q == IDLE) && bus.in_valid && (bus.alop == ALU_MUL);
  shift_add_mul #(.W(W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (product)
  );
  always_comb begin
    is_sub   = bus.alop == ALU_SUB;
    is_arith = is_sub || (bus.alop == ALU_ADD);
    bb       = is_sub ? ~bus.b : bus.b;
    sum      = {1'b0, bus.a} + {1'b0, bb} + {{W{1'b0}}, is_sub ? 1'b1 : bus.c_in};
    alu_c    = is_arith && sum[W];
    alu_v    = is_arith && (bus.a[W-1] == bb[W-1]) && (sum[W-1] != bus.a[W-1]);
    alu_r    = '0;
    case (bus.alop)
      ALU_AND: alu_r = bus.a & bus.b;
      ALU_OR:  alu_r = bus.a | bus.b;
      ALU_ADD: alu_r = sum[W-1:0];
      ALU_SUB: alu_r = sum[W-1:0];
      ALU_XOR: alu_r = bus.a ^ bus.b;
      ALU_SLT: alu_r = {{(W-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      ALU_SLL: alu_r = bus.a << bus.b[SHW-1:0];
      ALU_MUL: alu_r = '0;
    endcase
  end
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        if (bus.alop == ALU_MUL) state_d = MUL;
        else begin
          result_d = alu_r;
          flags_d  = '{z: alu_r == '0, n: alu_r[W-1], c: alu_c, v: alu_v};
          state_d  = DONE;
        end
      end
      MUL: if (mul_done) begin
        result_d = product[W-1:0];
        flags_d  = '{z: product[W-1:0] == '0, n: product[W-1], c: |product[2*W-1:W], v: 1'b0};
        state_d  = DONE;
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.result    = result_q;
  assign bus.flag_z    = flags_q.z;
  assign bus.flag_n    = flags_q.n;
  assign bus.flag_c    = flags_q.c;
  assign bus.flag_v    = flags_q.v;
endmodule

// File: tb/tb_seq_nbit_alu.sv
// tb_seq_nbit_alu: directed self-checking bench for seq_nbit_alu at W=32
module tb_seq_nbit_alu;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  seq_nbit_alu_if #(.W(32)) bus ();
  seq_nbit_alu #(.W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic issue(input alop_t op, input logic [31:0] ia, input logic [31:0] ib, input logic ic);
    bus.in_valid = 1'b1;
    bus.alop     = op;
    bus.a        = ia;
    bus.b        = ib;
    bus.c_in     = ic;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_out(output int n, output logic busy_ok);
    n = 1;
    busy_ok = 1'b1;
    while (!bus.out_valid && n < 100) begin
      if (bus.in_ready) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
  endtask
  task automatic run(input string tag, input alop_t op, input logic [31:0] ia, input logic [31:0] ib,
                     input logic ic, input int lat, input logic [31:0] er, input logic [3:0] ef);
    int n;
    logic busy_ok;
    issue(op, ia, ib, ic);
    wait_out(n, busy_ok);
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    if (lat > 1) chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
    chk({tag, "_res"}, 64'(bus.result), 64'(er));
    chk({tag, "_flags"}, 64'({bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}), 64'(ef));
    @(negedge clk);
    chk({tag, "_ready_after"}, 64'({bus.in_ready, bus.out_valid}), 64'b10);
  endtask
  initial begin
    int n;
    logic seen;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.c_in      = 1'b0;
    bus.alop      = ALU_AND;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_hs", 64'({bus.in_ready, bus.out_valid}), 64'b10);
    chk("reset_res", 64'(bus.result), 64'd0);
    chk("reset_flags", 64'({bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}), 64'd0);
    bus.out_ready = 1'b1;
    run("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1, 32'h0000_0000, 4'b1010);
    run("sub_ovf", ALU_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1, 32'h8000_0000, 4'b0101);
    run("slt_neg", ALU_SLT, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1, 32'h0000_0001, 4'b0000);
    run("add_cin", ALU_ADD, 32'd5, 32'd6, 1'b1, 1, 32'd12, 4'b0000);
    run("or", ALU_OR, 32'h0000_00F0, 32'h0000_000F, 1'b0, 1, 32'h0000_00FF, 4'b0000);
    run("mul_hi", ALU_MUL, 32'h0001_0000, 32'h0001_0000, 1'b0, 33, 32'h0000_0000, 4'b1010);
    run("mul_small", ALU_MUL, 32'd7, 32'd6, 1'b0, 33, 32'd42, 4'b0000);
    run("mul_max", ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33, 32'h0000_0001, 4'b0010);
    bus.out_ready = 1'b0;
    issue(ALU_ADD, 32'd3, 32'd4, 1'b0);
    chk("bp_first_valid", 64'(bus.out_valid), 64'd1);
    bus.in_valid = 1'b1;
    bus.alop     = ALU_XOR;
    bus.a        = 32'h0000_00FF;
    bus.b        = 32'h0000_000F;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", 64'({bus.out_valid, bus.in_ready, bus.result}), {30'd0, 2'b10, 32'd7});
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 64'({bus.in_ready, bus.out_valid}), 64'b10);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_second", 64'({bus.out_valid, bus.result}), {31'd0, 1'b1, 32'h0000_00F0});
    @(negedge clk);
    issue(ALU_MUL, 32'h0001_2345, 32'h0000_6789, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_hs", 64'({bus.in_ready, bus.out_valid}), 64'b10);
    chk("rst_mid_res", 64'({bus.result, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("rst_mid_no_out", 64'(seen), 64'd0);
    run("and_after_rst", ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1, 32'hF000_F000, 4'b0100);
    run("sll_31", ALU_SLL, 32'h0000_0001, 32'h0000_003F, 1'b0, 1, 32'h8000_0000, 4'b0100);
    run("sll_0", ALU_SLL, 32'h0000_1234, 32'h0000_0020, 1'b0, 1, 32'h0000_1234, 4'b0000);
    run("xor", ALU_XOR, 32'hAAAA_5555, 32'hAAAA_5555, 1'b0, 1, 32'h0000_0000, 4'b1000);
    n = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
